// File: rtl/noc_output_ctrl_if.sv
// Router output-port bus: per-VC flit/valid/credit side toward the crossbar,
// registered link side toward the downstream router.
// Optional feature macro (used by noc_output_ctrl): NOC_OUTPUT_CTRL_PKT_LOCK_EN.
interface noc_output_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_VC     = 2
);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic [NUM_VC-1:0]            vc_valid;
    logic [NUM_VC*DATA_WIDTH-1:0] vc_data;
    logic [NUM_VC-1:0]            vc_ready;
    logic [NUM_VC-1:0]            credit_in;
    logic [NUM_VC-1:0]            full_ret;
    logic                         write;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [VCW-1:0]               out_vc;
    logic                         credit_err;

    // Upstream / environment side
    modport master (
        output vc_valid, vc_data, credit_in,
        input  vc_ready, full_ret, write, out_data, out_vc, credit_err
    );

    // Output controller side
    modport slave (
        input  vc_valid, vc_data, credit_in,
        output vc_ready, full_ret, write, out_data, out_vc, credit_err
    );
endinterface

// File: rtl/noc_output_ctrl.sv
// Router output-port controller: round-robin arbitration of NUM_VC virtual
// channels onto one registered link with per-VC credit flow control.
// An all-zero flit is idle and never requested, granted or counted.
// Optional wormhole lock: define NOC_OUTPUT_CTRL_PKT_LOCK_EN. A head flit
// (type 2'b01 in the two MSBs) locks the arbiter to its VC; a tail flit
// (2'b11) releases it in its own grant cycle.
module noc_output_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_VC       = 2,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    noc_output_ctrl_if.slave   bus
);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW  = $clog2(CREDIT_DEPTH + 1);

    logic [DATA_WIDTH-1:0] flit [NUM_VC];
    logic [NUM_VC-1:0]     req;
    logic                  gnt_found;
    logic [VCW-1:0]        gnt_idx;
    logic [NUM_VC-1:0]     gnt_oh;
    logic [DATA_WIDTH-1:0] sel_flit;

    logic [CW-1:0]         credit_q [NUM_VC];
    logic [CW-1:0]         credit_d [NUM_VC];
    logic [VCW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [VCW-1:0]        out_vc_q, out_vc_d;
    logic                  credit_err_q, credit_err_d;

`ifdef NOC_OUTPUT_CTRL_PKT_LOCK_EN
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;
    logic                  lock_q, lock_d;
    logic [VCW-1:0]        lock_vc_q, lock_vc_d;
`endif

    // Slice the packed flit bus into per-VC flits
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            flit[i] = bus.vc_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A VC requests when it holds a non-idle flit and has downstream space
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            req[i] = bus.vc_valid[i] && (flit[i] != '0) && (credit_q[i] != '0);
`ifdef NOC_OUTPUT_CTRL_PKT_LOCK_EN
            if (lock_q && (VCW'(i) != lock_vc_q)) begin
                req[i] = 1'b0;
            end
`endif
        end
    end

    // Round-robin search starting at rr_ptr, wrapping past the last VC
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (!gnt_found && req[(int'(rr_ptr_q) + k) % NUM_VC]) begin
                gnt_found = 1'b1;
                gnt_idx   = VCW'((int'(rr_ptr_q) + k) % NUM_VC);
            end
        end
        gnt_oh   = gnt_found ? (NUM_VC'(1) << gnt_idx) : '0;
        sel_flit = flit[gnt_idx];
    end

    // Next link register, pointer, credit and lock state
    always_comb begin
        write_d      = gnt_found;
        out_data_d   = out_data_q;
        out_vc_d     = out_vc_q;
        rr_ptr_d     = rr_ptr_q;
        credit_err_d = credit_err_q;
        credit_d     = credit_q;
        if (gnt_found) begin
            out_data_d = sel_flit;
            out_vc_d   = gnt_idx;
            rr_ptr_d   = VCW'((int'(gnt_idx) + 1) % NUM_VC);
        end
        for (int i = 0; i < NUM_VC; i++) begin
            case ({gnt_oh[i], bus.credit_in[i]})
                2'b10: credit_d[i] = credit_q[i] - CW'(1);
                2'b01: begin
                    // Returning a credit that was never taken: saturate and flag
                    if (credit_q[i] == CW'(CREDIT_DEPTH)) begin
                        credit_err_d = 1'b1;
                    end else begin
                        credit_d[i] = credit_q[i] + CW'(1);
                    end
                end
                default: ;
            endcase
        end
`ifdef NOC_OUTPUT_CTRL_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        if (gnt_found) begin
            if (sel_flit[DATA_WIDTH-1 -: 2] == FT_HEAD) begin
                lock_d    = 1'b1;
                lock_vc_d = gnt_idx;
            end else if (sel_flit[DATA_WIDTH-1 -: 2] == FT_TAIL) begin
                lock_d = 1'b0;
            end
        end
`endif
    end

    // State registers; reset drops any in-flight link flit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q      <= 1'b0;
            out_data_q   <= '0;
            out_vc_q     <= '0;
            rr_ptr_q     <= '0;
            credit_err_q <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                credit_q[i] <= CW'(CREDIT_DEPTH);
            end
`ifdef NOC_OUTPUT_CTRL_PKT_LOCK_EN
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
`endif
        end else begin
            write_q      <= write_d;
            out_data_q   <= out_data_d;
            out_vc_q     <= out_vc_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_err_q <= credit_err_d;
            credit_q     <= credit_d;
`ifdef NOC_OUTPUT_CTRL_PKT_LOCK_EN
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
`endif
        end
    end

    // Downstream-full flags straight from the credit counters
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            bus.full_ret[i] = (credit_q[i] == '0);
        end
    end

    assign bus.vc_ready   = gnt_oh;
    assign bus.write      = write_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_vc     = out_vc_q;
    assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_ctrl.sv
// Self-checking bench for noc_output_ctrl (DATA_WIDTH=8, NUM_VC=2, CREDIT_DEPTH=4).
// Each cycle vector carries the hand-computed grant; a granted flit is queued
// and a separate monitor compares it against the link one cycle later.
module tb_noc_output_ctrl;
    localparam int DW = 8;
    localparam int NV = 2;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [8:0] exp_q [$];

    noc_output_ctrl_if #(.DATA_WIDTH(DW), .NUM_VC(NV)) bus ();

    noc_output_ctrl #(.DATA_WIDTH(DW), .NUM_VC(NV), .CREDIT_DEPTH(CD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Link monitor: every write must match the oldest expected flit
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst_n && bus.write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got vc %0d data 0x%0h, expected no write",
                         bus.out_vc, bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("link_vc_data", {23'd0, bus.out_vc, bus.out_data}, {23'd0, e});
            end
        end
    end

    // One clock cycle: drive inputs, check grant/full, queue the expected flit
    task automatic cyc(input string name, input logic [1:0] v, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] cin,
                       input logic [1:0] exp_rdy, input logic [1:0] exp_full);
        bus.vc_valid  = v;
        bus.vc_data   = {d1, d0};
        bus.credit_in = cin;
        @(negedge clk);
        chk({name, "_ready"}, {30'd0, bus.vc_ready}, {30'd0, exp_rdy});
        chk({name, "_full"}, {30'd0, bus.full_ret}, {30'd0, exp_full});
        if (exp_rdy == 2'b01) exp_q.push_back({1'b0, d0});
        else if (exp_rdy == 2'b10) exp_q.push_back({1'b1, d1});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.vc_valid  = '0;
        bus.vc_data   = '0;
        bus.credit_in = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.vc_valid  = '0;
        bus.vc_data   = '0;
        bus.credit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_write", {31'd0, bus.write}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_out_vc", {31'd0, bus.out_vc}, 32'd0);
        chk("rst_full", {30'd0, bus.full_ret}, 32'd0);
        chk("rst_ready", {30'd0, bus.vc_ready}, 32'd0);
        chk("rst_err", {31'd0, bus.credit_err}, 32'd0);

        // VC0 drains its 4 credits, then stalls
        cyc("t1c1", 2'b01, 8'h11, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t1c2", 2'b01, 8'h12, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t1c3", 2'b01, 8'h13, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t1c4", 2'b01, 8'h14, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t1c5", 2'b01, 8'h15, 8'h00, 2'b00, 2'b00, 2'b01);
        cyc("t1c6", 2'b01, 8'h15, 8'h00, 2'b00, 2'b00, 2'b01);
        // One returned credit: no same-cycle bypass, one grant next cycle
        cyc("t2c1", 2'b01, 8'h15, 8'h00, 2'b01, 2'b00, 2'b01);
        cyc("t2c2", 2'b01, 8'h15, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t2c3", 2'b01, 8'h16, 8'h00, 2'b00, 2'b00, 2'b01);

        // Two VCs alternate
        do_reset();
        cyc("t3c1", 2'b11, 8'hA0, 8'hB0, 2'b00, 2'b01, 2'b00);
        cyc("t3c2", 2'b11, 8'hA1, 8'hB0, 2'b00, 2'b10, 2'b00);
        cyc("t3c3", 2'b11, 8'hA1, 8'hB1, 2'b00, 2'b01, 2'b00);
        cyc("t3c4", 2'b11, 8'hA2, 8'hB1, 2'b00, 2'b10, 2'b00);
        cyc("t3c5", 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);

        // Zero flit on VC1 is idle; its credit stays full, so a credit_in overflows
        do_reset();
        cyc("t4c1", 2'b10, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
        cyc("t4c2", 2'b10, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
        cyc("t4c3", 2'b10, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
        chk("t4_err_before", {31'd0, bus.credit_err}, 32'd0);
        cyc("t4c4", 2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 2'b00);
        chk("t4_err_set", {31'd0, bus.credit_err}, 32'd1);
        cyc("t4c5", 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
        chk("t4_err_sticky", {31'd0, bus.credit_err}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_err_rst", {31'd0, bus.credit_err}, 32'd0);
        chk("t4_write_rst", {31'd0, bus.write}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Grant and credit_in together at credit 2 leaves credit at 2
        do_reset();
        cyc("t5c1", 2'b01, 8'h21, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t5c2", 2'b01, 8'h22, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t5c3", 2'b01, 8'h23, 8'h00, 2'b01, 2'b01, 2'b00);
        cyc("t5c4", 2'b01, 8'h24, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t5c5", 2'b01, 8'h25, 8'h00, 2'b00, 2'b01, 2'b00);
        cyc("t5c6", 2'b01, 8'h26, 8'h00, 2'b00, 2'b00, 2'b01);

        // Head 0x41 on VC0, two stall cycles, tail 0xC1; VC1 offers 0xC5 throughout
        do_reset();
`ifdef NOC_OUTPUT_CTRL_PKT_LOCK_EN
        cyc("t6c1", 2'b11, 8'h41, 8'hC5, 2'b00, 2'b01, 2'b00);
        cyc("t6c2", 2'b10, 8'h00, 8'hC5, 2'b00, 2'b00, 2'b00);
        cyc("t6c3", 2'b10, 8'h00, 8'hC5, 2'b00, 2'b00, 2'b00);
        cyc("t6c4", 2'b11, 8'hC1, 8'hC5, 2'b00, 2'b01, 2'b00);
        cyc("t6c5", 2'b10, 8'h00, 8'hC5, 2'b00, 2'b10, 2'b00);
        cyc("t6c6", 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
`else
        cyc("t6c1", 2'b11, 8'h41, 8'hC5, 2'b00, 2'b01, 2'b00);
        cyc("t6c2", 2'b10, 8'h00, 8'hC5, 2'b00, 2'b10, 2'b00);
        cyc("t6c3", 2'b10, 8'h00, 8'hC5, 2'b00, 2'b10, 2'b00);
        cyc("t6c4", 2'b11, 8'hC1, 8'hC5, 2'b00, 2'b01, 2'b00);
        cyc("t6c5", 2'b10, 8'h00, 8'hC5, 2'b00, 2'b10, 2'b00);
        cyc("t6c6", 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
`endif

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
